// File: rtl/reorder_buffer_mw.sv
// rtl/reorder_buffer_mw.sv - multi-commit reorder buffer with CDB completion and redirect flush
// Define ROB_CDB_BYPASS_EN to forward same-cycle CDB results onto the operand lookup ports.
module reorder_buffer_mw #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int ROB_DEPTH      = 64,
    parameter int TAG_WIDTH      = $clog2(ROB_DEPTH),
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CDB_PORTS      = 2,
    parameter int COMMIT_WIDTH   = 2
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic                                 i_disp_en,
    input  logic                                 i_disp_rdy,
    input  logic                                 i_disp_redirect,
    input  logic [ADDR_WIDTH-1:0]                i_disp_iaddr,
    input  logic [DATA_WIDTH-1:0]                i_disp_data,
    input  logic [REG_ADDR_WIDTH-1:0]            i_disp_rdest,
    output logic [TAG_WIDTH-1:0]                 o_disp_tag,
    output logic                                 o_full,
    input  logic [CDB_PORTS-1:0]                 i_cdb_en,
    input  logic [CDB_PORTS-1:0]                 i_cdb_redirect,
    input  logic [CDB_PORTS*TAG_WIDTH-1:0]       i_cdb_tag,
    input  logic [CDB_PORTS*DATA_WIDTH-1:0]      i_cdb_data,
    input  logic [CDB_PORTS*ADDR_WIDTH-1:0]      i_cdb_addr,
    input  logic [2*TAG_WIDTH-1:0]               i_lookup_tag,
    output logic [1:0]                           o_lookup_rdy,
    output logic [2*DATA_WIDTH-1:0]              o_lookup_data,
    output logic                                 o_tag_wr_en,
    output logic [REG_ADDR_WIDTH-1:0]            o_tag_wr_rdest,
    output logic [TAG_WIDTH-1:0]                 o_tag_wr_tag,
    output logic [COMMIT_WIDTH-1:0]              o_dest_wr_en,
    output logic [COMMIT_WIDTH*REG_ADDR_WIDTH-1:0] o_dest_wr_rdest,
    output logic [COMMIT_WIDTH*TAG_WIDTH-1:0]    o_dest_wr_tag,
    output logic [COMMIT_WIDTH*DATA_WIDTH-1:0]   o_dest_wr_data,
    output logic                                 o_redirect,
    output logic [ADDR_WIDTH-1:0]                o_redirect_addr
);
    logic [ROB_DEPTH-1:0]      r_valid, r_rdy, r_redir;
    logic [DATA_WIDTH-1:0]     r_data  [ROB_DEPTH];
    logic [ADDR_WIDTH-1:0]     r_addr  [ROB_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] r_rdest [ROB_DEPTH];
    logic [TAG_WIDTH-1:0]      r_head, r_tail;
    logic [TAG_WIDTH:0]        r_count;
    logic                      r_redirect;
    logic [ADDR_WIDTH-1:0]     r_redirect_addr;

    logic [TAG_WIDTH-1:0]      w_cdb_tag [CDB_PORTS];
    logic [TAG_WIDTH-1:0]      w_cidx    [COMMIT_WIDTH];
    logic [TAG_WIDTH-1:0]      w_lk_tag  [2];
    logic [COMMIT_WIDTH-1:0]   w_retire;
    logic [TAG_WIDTH:0]        w_n;
    logic                      w_chain;
    logic                      w_flush;
    logic [ADDR_WIDTH-1:0]     w_flush_addr;
    logic                      w_full;
    logic                      w_disp;

    genvar g;
    for (g = 0; g < CDB_PORTS; g++) begin : g_cdb
        assign w_cdb_tag[g] = i_cdb_tag[g*TAG_WIDTH +: TAG_WIDTH];
    end
    for (g = 0; g < COMMIT_WIDTH; g++) begin : g_cidx
        assign w_cidx[g] = r_head + TAG_WIDTH'(g);
    end
    for (g = 0; g < 2; g++) begin : g_lk
        assign w_lk_tag[g] = i_lookup_tag[g*TAG_WIDTH +: TAG_WIDTH];
    end

    // A pending flush blocks dispatch so nothing lands in a buffer about to be cleared.
    assign w_full          = (r_count == (TAG_WIDTH+1)'(ROB_DEPTH)) | w_flush;
    assign w_disp          = i_disp_en & ~w_full;
    assign o_full          = w_full;
    assign o_disp_tag      = r_tail;
    assign o_tag_wr_en     = w_disp & (i_disp_rdest != '0);
    assign o_tag_wr_rdest  = w_disp ? i_disp_rdest : '0;
    assign o_tag_wr_tag    = r_tail;
    assign o_redirect      = r_redirect;
    assign o_redirect_addr = r_redirect_addr;

    // Retirement chain: stops at the first incomplete entry, or after a redirecting one.
    always_comb begin
        w_retire        = '0;
        w_n             = '0;
        w_chain         = 1'b1;
        w_flush         = 1'b0;
        w_flush_addr    = '0;
        o_dest_wr_en    = '0;
        o_dest_wr_rdest = '0;
        o_dest_wr_tag   = '0;
        o_dest_wr_data  = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (w_chain && r_valid[w_cidx[k]] && r_rdy[w_cidx[k]]) begin
                w_retire[k] = 1'b1;
                w_n         = w_n + (TAG_WIDTH+1)'(1);
                o_dest_wr_en[k] = (r_rdest[w_cidx[k]] != '0);
                o_dest_wr_rdest[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = r_rdest[w_cidx[k]];
                o_dest_wr_tag[k*TAG_WIDTH +: TAG_WIDTH]             = w_cidx[k];
                o_dest_wr_data[k*DATA_WIDTH +: DATA_WIDTH]          = r_data[w_cidx[k]];
                if (r_redir[w_cidx[k]]) begin
                    w_flush      = 1'b1;
                    w_flush_addr = r_addr[w_cidx[k]];
                    w_chain      = 1'b0;
                end
            end else begin
                w_chain = 1'b0;
            end
        end
    end

    always_comb begin
        o_lookup_rdy  = '0;
        o_lookup_data = '0;
        for (int i = 0; i < 2; i++) begin
            if (r_valid[w_lk_tag[i]] && r_rdy[w_lk_tag[i]]) begin
                o_lookup_rdy[i] = 1'b1;
                o_lookup_data[i*DATA_WIDTH +: DATA_WIDTH] = r_data[w_lk_tag[i]];
            end
`ifdef ROB_CDB_BYPASS_EN
            for (int p = CDB_PORTS-1; p >= 0; p--) begin
                if (i_cdb_en[p] && r_valid[w_lk_tag[i]] && (w_cdb_tag[p] == w_lk_tag[i])) begin
                    o_lookup_rdy[i] = 1'b1;
                    o_lookup_data[i*DATA_WIDTH +: DATA_WIDTH] = i_cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`endif
        end
    end

    // Lanes are walked high to low so the lowest lane's write is the one that sticks.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_valid         <= '0;
            r_rdy           <= '0;
            r_redir         <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_redirect      <= 1'b0;
            r_redirect_addr <= '0;
        end else begin
            r_redirect      <= w_flush;
            r_redirect_addr <= w_flush ? w_flush_addr : '0;
            for (int p = CDB_PORTS-1; p >= 0; p--) begin
                if (i_cdb_en[p] && r_valid[w_cdb_tag[p]]) begin
                    r_rdy[w_cdb_tag[p]]   <= 1'b1;
                    r_redir[w_cdb_tag[p]] <= i_cdb_redirect[p];
                end
            end
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (w_retire[k]) r_valid[w_cidx[k]] <= 1'b0;
            end
            if (w_disp) begin
                r_valid[r_tail] <= 1'b1;
                r_rdy[r_tail]   <= i_disp_rdy;
                r_redir[r_tail] <= i_disp_rdy & i_disp_redirect;
            end
            if (w_flush) begin
                r_valid <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + w_n[TAG_WIDTH-1:0];
                r_tail  <= r_tail + TAG_WIDTH'(w_disp);
                r_count <= r_count + (TAG_WIDTH+1)'(w_disp) - w_n;
            end
        end
    end

    // Payload needs no reset: it is only observed behind a valid/rdy flag.
    always_ff @(posedge clk) begin
        for (int p = CDB_PORTS-1; p >= 0; p--) begin
            if (i_cdb_en[p] && r_valid[w_cdb_tag[p]]) begin
                r_data[w_cdb_tag[p]] <= i_cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
                r_addr[w_cdb_tag[p]] <= i_cdb_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        if (w_disp) begin
            r_data[r_tail]  <= i_disp_data;
            r_addr[r_tail]  <= i_disp_iaddr;
            r_rdest[r_tail] <= i_disp_rdest;
        end
    end
endmodule

// File: tb/tb_reorder_buffer_mw.sv
// tb/tb_reorder_buffer_mw.sv - scoreboard bench for reorder_buffer_mw against a queue-based program-order model
module tb_reorder_buffer_mw;
    localparam int DEPTH = 64;
`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        i_disp_en, i_disp_rdy, i_disp_redirect;
    logic [31:0] i_disp_iaddr, i_disp_data;
    logic [4:0]  i_disp_rdest;
    logic [5:0]  o_disp_tag;
    logic        o_full;
    logic [1:0]  i_cdb_en, i_cdb_redirect;
    logic [11:0] i_cdb_tag;
    logic [63:0] i_cdb_data, i_cdb_addr;
    logic [11:0] i_lookup_tag;
    logic [1:0]  o_lookup_rdy;
    logic [63:0] o_lookup_data;
    logic        o_tag_wr_en;
    logic [4:0]  o_tag_wr_rdest;
    logic [5:0]  o_tag_wr_tag;
    logic [1:0]  o_dest_wr_en;
    logic [9:0]  o_dest_wr_rdest;
    logic [11:0] o_dest_wr_tag;
    logic [63:0] o_dest_wr_data;
    logic        o_redirect;
    logic [31:0] o_redirect_addr;

    reorder_buffer_mw dut (
        .clk(clk), .n_rst(n_rst),
        .i_disp_en(i_disp_en), .i_disp_rdy(i_disp_rdy), .i_disp_redirect(i_disp_redirect),
        .i_disp_iaddr(i_disp_iaddr), .i_disp_data(i_disp_data), .i_disp_rdest(i_disp_rdest),
        .o_disp_tag(o_disp_tag), .o_full(o_full),
        .i_cdb_en(i_cdb_en), .i_cdb_redirect(i_cdb_redirect), .i_cdb_tag(i_cdb_tag),
        .i_cdb_data(i_cdb_data), .i_cdb_addr(i_cdb_addr),
        .i_lookup_tag(i_lookup_tag), .o_lookup_rdy(o_lookup_rdy), .o_lookup_data(o_lookup_data),
        .o_tag_wr_en(o_tag_wr_en), .o_tag_wr_rdest(o_tag_wr_rdest), .o_tag_wr_tag(o_tag_wr_tag),
        .o_dest_wr_en(o_dest_wr_en), .o_dest_wr_rdest(o_dest_wr_rdest),
        .o_dest_wr_tag(o_dest_wr_tag), .o_dest_wr_data(o_dest_wr_data),
        .o_redirect(o_redirect), .o_redirect_addr(o_redirect_addr)
    );

    always #5 clk = ~clk;

    typedef struct {int tag; logic [4:0] rdest; bit done; bit redir; logic [31:0] data; logic [31:0] addr;} ent_t;
    typedef struct {int lane; logic [4:0] rdest; int tag; logic [31:0] data; int due;} cexp_t;
    typedef struct {logic [31:0] addr; int due;} rexp_t;

    ent_t  rob[$];
    cexp_t cq[$];
    rexp_t rq[$];
    int    tail_m, cyc, n_tests, n_fail;

    bit          s_de, s_drdy, s_dredir;
    logic [31:0] s_iaddr, s_ddata;
    logic [4:0]  s_rdest;
    bit          s_cen[2], s_credir[2];
    logic [5:0]  s_ctag[2], s_lk[2];
    logic [31:0] s_cdata[2], s_caddr[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int find(input int tag);
        for (int i = 0; i < rob.size(); i++) if (rob[i].tag == tag) return i;
        return -1;
    endfunction

    task automatic clear_stim();
        s_de = 0; s_drdy = 0; s_dredir = 0; s_iaddr = '0; s_ddata = '0; s_rdest = '0;
        for (int p = 0; p < 2; p++) begin
            s_cen[p] = 0; s_credir[p] = 0; s_ctag[p] = '0; s_cdata[p] = '0; s_caddr[p] = '0; s_lk[p] = '0;
        end
    endtask

    task automatic drive_inputs();
        i_disp_en = s_de; i_disp_rdy = s_drdy; i_disp_redirect = s_dredir;
        i_disp_iaddr = s_iaddr; i_disp_data = s_ddata; i_disp_rdest = s_rdest;
        i_cdb_en = {s_cen[1], s_cen[0]}; i_cdb_redirect = {s_credir[1], s_credir[0]};
        i_cdb_tag = {s_ctag[1], s_ctag[0]}; i_cdb_data = {s_cdata[1], s_cdata[0]};
        i_cdb_addr = {s_caddr[1], s_caddr[0]}; i_lookup_tag = {s_lk[1], s_lk[0]};
    endtask

    // One clock of stimulus: checks the pre-edge view, then advances the model across the edge.
    task automatic step();
        int n, idx; bit fl, full_e, acc, lr; logic [31:0] fa, ld; ent_t e; cexp_t c; rexp_t r;
        @(negedge clk);
        cyc++;
        drive_inputs();
        #1;
        n = 0; fl = 0; fa = '0;
        for (int k = 0; k < 2; k++) begin
            if (k >= rob.size() || !rob[k].done) break;
            n++;
            if (rob[k].rdest != 0) begin
                c.lane = k; c.rdest = rob[k].rdest; c.tag = rob[k].tag; c.data = rob[k].data; c.due = cyc;
                cq.push_back(c);
            end
            if (rob[k].redir) begin fl = 1; fa = rob[k].addr; break; end
        end
        full_e = (rob.size() == DEPTH) || fl;
        chk("o_full", o_full, full_e);
        chk("o_disp_tag", o_disp_tag, tail_m);
        acc = s_de && !full_e;
        chk("o_tag_wr_en", o_tag_wr_en, acc && (s_rdest != 0));
        if (acc && s_rdest != 0) begin
            chk("o_tag_wr_rdest", o_tag_wr_rdest, s_rdest);
            chk("o_tag_wr_tag", o_tag_wr_tag, tail_m);
        end
        for (int i = 0; i < 2; i++) begin
            idx = find(s_lk[i]); lr = 0; ld = '0;
            if (idx >= 0 && rob[idx].done) begin lr = 1; ld = rob[idx].data; end
            if (BYP && idx >= 0) begin
                for (int p = 0; p < 2; p++) if (s_cen[p] && s_ctag[p] == s_lk[i]) begin lr = 1; ld = s_cdata[p]; break; end
            end
            chk("lookup_rdy", o_lookup_rdy[i], lr);
            chk("lookup_data", o_lookup_data[i*32 +: 32], ld);
        end
        for (int p = 0; p < 2; p++) begin
            if (s_cen[p] && !(p == 1 && s_cen[0] && s_ctag[0] == s_ctag[1])) begin
                idx = find(s_ctag[p]);
                if (idx >= 0) begin
                    e = rob[idx]; e.done = 1; e.data = s_cdata[p]; e.redir = s_credir[p]; e.addr = s_caddr[p];
                    rob[idx] = e;
                end
            end
        end
        for (int k = 0; k < n; k++) void'(rob.pop_front());
        if (fl) begin
            rob.delete(); tail_m = 0;
            r.addr = fa; r.due = cyc + 1; rq.push_back(r);
        end else if (acc) begin
            e.tag = tail_m; e.rdest = s_rdest; e.done = s_drdy; e.redir = s_drdy && s_dredir;
            e.data = s_ddata; e.addr = s_iaddr;
            rob.push_back(e);
            tail_m = (tail_m + 1) % DEPTH;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin clear_stim(); step(); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 0; clear_stim(); drive_inputs();
        rob.delete(); cq.delete(); rq.delete(); tail_m = 0;
        @(negedge clk); #1;
        chk("rst_full", o_full, 0);
        chk("rst_disp_tag", o_disp_tag, 0);
        chk("rst_dest_wr_en", o_dest_wr_en, 0);
        chk("rst_redirect", o_redirect, 0);
        chk("rst_redirect_addr", o_redirect_addr, 0);
        chk("rst_lookup_rdy", o_lookup_rdy, 0);
        n_rst = 1;
    endtask

    task automatic drain();
        int it; int nd[$];
        for (it = 0; it < 300 && rob.size() > 0; it++) begin
            clear_stim(); nd.delete();
            foreach (rob[i]) if (!rob[i].done) nd.push_back(rob[i].tag);
            for (int p = 0; p < 2 && p < nd.size(); p++) begin
                s_cen[p] = 1; s_ctag[p] = 6'(nd[p]); s_cdata[p] = $urandom;
            end
            step();
        end
        if (rob.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d entries still outstanding, required 0", rob.size());
        end
        idle(3);
    endtask

    task automatic rand_stim();
        int nd[$];
        clear_stim();
        s_de = ($urandom_range(0, 99) < 55);
        s_drdy = ($urandom_range(0, 9) == 0);
        s_dredir = s_drdy && ($urandom_range(0, 7) == 0);
        s_iaddr = $urandom; s_ddata = $urandom; s_rdest = 5'($urandom_range(0, 31));
        foreach (rob[i]) if (!rob[i].done) nd.push_back(rob[i].tag);
        for (int p = 0; p < 2; p++) begin
            if (nd.size() > 0 && $urandom_range(0, 99) < 45) begin
                s_cen[p] = 1; s_ctag[p] = 6'(nd[$urandom_range(0, nd.size() - 1)]);
            end else if ($urandom_range(0, 99) < 8) begin
                s_cen[p] = 1; s_ctag[p] = 6'($urandom_range(0, 63));
            end
            s_credir[p] = ($urandom_range(0, 99) < 4);
            s_cdata[p] = $urandom; s_caddr[p] = $urandom;
            if (rob.size() > 0 && $urandom_range(0, 3) != 0) s_lk[p] = 6'(rob[$urandom_range(0, rob.size() - 1)].tag);
            else s_lk[p] = 6'($urandom_range(0, 63));
        end
    endtask

    // Monitor: consumes expected retirements and redirects independently of the stimulus.
    initial begin
        cexp_t c; rexp_t r;
        forever begin
            @(negedge clk); #2;
            for (int k = 0; k < 2; k++) begin
                if (o_dest_wr_en[k]) begin
                    if (cq.size() == 0) chk("commit_unexpected", o_dest_wr_en[k], 0);
                    else begin
                        c = cq.pop_front();
                        chk("commit_lane", k, c.lane);
                        chk("commit_rdest", o_dest_wr_rdest[k*5 +: 5], c.rdest);
                        chk("commit_tag", o_dest_wr_tag[k*6 +: 6], c.tag);
                        chk("commit_data", o_dest_wr_data[k*32 +: 32], c.data);
                    end
                end
            end
            while (cq.size() > 0 && cq[0].due <= cyc) begin
                c = cq.pop_front();
                chk("commit_missing", o_dest_wr_en[c.lane], 1);
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                chk("redirect_pulse", o_redirect, 1);
                chk("redirect_addr", o_redirect_addr, r.addr);
            end else if (o_redirect) begin
                chk("redirect_unexpected", o_redirect, 0);
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; tail_m = 0;
        clear_stim(); drive_inputs();
        do_reset();

        for (int i = 0; i < 65; i++) begin
            clear_stim(); s_de = 1; s_rdest = 5'(i % 31 + 1); s_ddata = $urandom; s_iaddr = 32'(i * 4);
            step();
        end
        chk("fill_full", o_full, 1);
        chk("fill_tail_wrap", o_disp_tag, 0);
        drain();

        clear_stim(); s_de = 1; s_rdest = 5'd3; step();
        clear_stim(); s_de = 1; s_rdest = 5'd4; step();
        clear_stim(); s_cen[0] = 1; s_ctag[0] = 6'd0; s_cdata[0] = 32'hA;
        s_cen[1] = 1; s_ctag[1] = 6'd1; s_cdata[1] = 32'hB; step();
        idle(1);
        chk("dual_en", o_dest_wr_en, 2'b11);
        chk("dual_data", o_dest_wr_data, {32'hB, 32'hA});
        idle(1);

        clear_stim(); s_de = 1; s_rdest = 5'd5; step();
        clear_stim(); s_de = 1; s_rdest = 5'd6; step();
        clear_stim(); s_cen[0] = 1; s_ctag[0] = 6'd3; s_cdata[0] = 32'h33; step();
        idle(1);
        chk("order_hold", o_dest_wr_en, 2'b00);
        clear_stim(); s_cen[0] = 1; s_ctag[0] = 6'd2; s_cdata[0] = 32'h22; step();
        idle(1);
        chk("order_both", o_dest_wr_en, 2'b11);
        idle(1);

        clear_stim(); s_de = 1; s_rdest = 5'd7; step();
        clear_stim(); s_de = 1; s_rdest = 5'd8; step();
        clear_stim(); s_cen[0] = 1; s_ctag[0] = 6'd4; s_cdata[0] = 32'h44; s_credir[0] = 1; s_caddr[0] = 32'h100;
        s_cen[1] = 1; s_ctag[1] = 6'd5; s_cdata[1] = 32'h55; step();
        idle(1);
        chk("misp_lane0_only", o_dest_wr_en, 2'b01);
        idle(1);
        chk("misp_redirect", o_redirect, 1);
        chk("misp_redirect_addr", o_redirect_addr, 32'h100);
        chk("misp_tail_reset", o_disp_tag, 0);
        chk("misp_tag5_dropped", o_dest_wr_en, 2'b00);

        for (int i = 0; i < 6; i++) begin clear_stim(); s_de = 1; s_rdest = 5'd1; step(); end
        clear_stim(); s_cen[1] = 1; s_ctag[1] = 6'd5; s_cdata[1] = 32'h55; s_lk[0] = 6'd5; step();
        chk("bypass_rdy", o_lookup_rdy[0], BYP);
        chk("bypass_data", o_lookup_data[31:0], BYP ? 32'h55 : 32'h0);
        drain();

        do_reset();
        for (int i = 0; i < 63; i++) begin clear_stim(); s_de = 1; s_drdy = 1; s_rdest = 5'd9; s_ddata = $urandom; step(); end
        idle(3);
        clear_stim(); s_de = 1; s_rdest = 5'd10; step();
        clear_stim(); s_de = 1; s_rdest = 5'd11; step();
        clear_stim(); s_cen[0] = 1; s_ctag[0] = 6'd63; s_cdata[0] = 32'h63;
        s_cen[1] = 1; s_ctag[1] = 6'd0; s_cdata[1] = 32'h100; step();
        clear_stim(); s_de = 1; s_rdest = 5'd12; step();
        chk("wrap_commit", o_dest_wr_en, 2'b11);
        chk("wrap_tags", o_dest_wr_tag, {6'd0, 6'd63});
        idle(1);
        chk("wrap_tail", o_disp_tag, 2);
        drain();

        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) do_reset();
            rand_stim();
            step();
        end
        drain();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
